vga_timing_receiver: RTL

- Sink-side counterpart of the team's VGA pixel generator. Samples incoming hsync/vsync/RGB on a pixel-rate strobe and recovers the horizontal and vertical position.
- Measures line length, frame length and sync widths.
- Locks once timing is stable, then emits pixel coordinates with a valid flag for the active window.
- Sits in front of capture/checker logic on the board loopback path.

---
 rtl/vga_timing_receiver.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_receiver.sv
// Sink-side VGA timing recovery: measures line/frame/sync geometry from the
// incoming syncs, locks on stable timing and emits active-window coordinates.
module vga_timing_receiver #(
  parameter int CNT_W       = 12,
  parameter bit SYNC_POL    = 1'b1,
  parameter int H_ACT_START = 181,
  parameter int H_ACT_END   = 1140,
  parameter int V_ACT_START = 31,
  parameter int V_ACT_END   = 665,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [3:0]       red_in,
  input  logic [3:0]       green_in,
  input  logic [3:0]       blue_in,
  output logic [10:0]      x,
  output logic [10:0]      y,
  output logic             pix_valid,
  output logic [3:0]       red_out,
  output logic [3:0]       green_out,
  output logic [3:0]       blue_out,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] hsync_width,
  output logic [CNT_W-1:0] vsync_width
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic             hs, vs, hs_d, vs_d;
  logic             hs_lead, hs_trail, vs_lead, vs_trail;
  logic [CNT_W-1:0] hcnt, vcnt, hsw_cnt, vsw_cnt;
  logic [CNT_W-1:0] h_len, h_cand, v_cand;
  logic [CNT_W-1:0] first_len, ref_h, ref_v;
  logic             have_first, line_bad, line_bad_now, h_sat;
  logic [3:0]       match, match_n;
  logic             ref_load;
  logic             in_win;
  int               hpos, vpos;

  assign hs       = (hsync_in == SYNC_POL);
  assign vs       = (vsync_in == SYNC_POL);
  assign hs_lead  = hs & ~hs_d;
  assign hs_trail = ~hs & hs_d;
  assign vs_lead  = vs & ~vs_d;
  assign vs_trail = ~vs & vs_d;

  // Lengths as they would be latched on this sample; the FSM compares these
  // so a frame edge coinciding with a line edge sees the just-finished line.
  assign h_len  = hcnt + 1'b1;
  assign h_cand = hs_lead ? h_len : h_total;
  assign v_cand = vcnt + 1'b1;

  // Counter is about to pin at all-ones: no hsync seen for a full counter span.
  assign h_sat = ~hs_lead & (hcnt >= CNT_MAX - 1'b1);

  assign line_bad_now = line_bad | (hs_lead & have_first & (h_len != first_len));

  assign hpos   = int'(hcnt);
  assign vpos   = int'(vcnt);
  assign in_win = locked &&
                  hpos >= H_ACT_START && hpos < H_ACT_END &&
                  vpos >= V_ACT_START && vpos < V_ACT_END;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    match_n  = match;
    ref_load = 1'b0;
    if (pix_en) begin
      case (state)
        SEARCH: begin
          if (vs_lead) begin
            state_n  = TRACK;
            ref_load = 1'b1;
            match_n  = '0;
          end
        end
        TRACK: begin
          if (vs_lead) begin
            if (!line_bad_now && h_cand == ref_h && v_cand == ref_v) begin
              match_n = match + 4'd1;
              if (int'(match_n) >= LOCK_FRAMES - 1) state_n = LOCKED;
            end else begin
              ref_load = 1'b1;
              match_n  = '0;
            end
          end
        end
        LOCKED: begin
          if (h_sat || (vs_lead && (line_bad_now || h_cand != ref_h || v_cand != ref_v))) begin
            state_n = SEARCH;
            match_n = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      hsw_cnt     <= '0;
      vsw_cnt     <= '0;
      h_total     <= '0;
      v_total     <= '0;
      hsync_width <= '0;
      vsync_width <= '0;
      first_len   <= '0;
      have_first  <= 1'b0;
      line_bad    <= 1'b0;
      ref_h       <= '0;
      ref_v       <= '0;
      match       <= '0;
      frame_start <= 1'b0;
      pix_valid   <= 1'b0;
      x           <= '0;
      y           <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hs_d        <= hs;
        vs_d        <= vs;
        frame_start <= vs_lead;

        if (hs_lead) begin
          h_total <= h_len;
          hcnt    <= '0;
        end else if (hcnt != CNT_MAX) begin
          hcnt <= h_len;
        end

        if (hs) begin
          if (hs_lead)                 hsw_cnt <= CNT_W'(1);
          else if (hsw_cnt != CNT_MAX) hsw_cnt <= hsw_cnt + 1'b1;
        end
        if (hs_trail) hsync_width <= hsw_cnt;

        // vsync wins over a coincident hsync edge
        if (vs_lead) begin
          v_total <= v_cand;
          vcnt    <= '0;
        end else if (hs_lead && vcnt != CNT_MAX) begin
          vcnt <= v_cand;
        end

        if (vs_lead)                                vsw_cnt <= CNT_W'(hs_lead);
        else if (vs && hs_lead && vsw_cnt != CNT_MAX) vsw_cnt <= vsw_cnt + 1'b1;
        if (vs_trail) vsync_width <= vsw_cnt;

        if (vs_lead) begin
          line_bad   <= 1'b0;
          have_first <= 1'b0;
        end else if (hs_lead) begin
          if (!have_first) begin
            first_len  <= h_len;
            have_first <= 1'b1;
          end else if (h_len != first_len) begin
            line_bad <= 1'b1;
          end
        end

        match <= match_n;
        if (ref_load) begin
          ref_h <= h_cand;
          ref_v <= v_cand;
        end

        pix_valid <= in_win;
        x         <= in_win ? 11'(hpos - H_ACT_START) : 11'd0;
        y         <= in_win ? 11'(vpos - V_ACT_START) : 11'd0;
        red_out   <= red_in;
        green_out <= green_in;
        blue_out  <= blue_in;
      end
    end
  end

endmodule
